// File: rtl/sid_write_sched.sv
// sid_write_sched: UART command parser, command FIFO and SID bus write issuer.
// Entries are {type, addr, arg}; a WAIT entry holds the queue for arg ticks.
module sid_write_sched #(
  parameter int DEPTH = 16
) (
  input  logic                   SYS_CLK,
  input  logic                   n_reset,
  input  logic                   clk_en,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             sid_addr,
  output logic [7:0]             sid_data,
  output logic                   sid_n_cs,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {P_ADDR, P_ARG} pst_t;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} st_t;

  pst_t          r_pst;
  logic          r_ptype;
  logic [7:0]    r_paddr;
  logic          r_ovf;
  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  st_t           r_st;
  st_t           w_st_nxt;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_ncs;
  logic          w_ncs_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic [16:0]   w_head;

  assign w_full  = r_level == (AW+1)'(DEPTH);
  assign w_empty = r_level == '0;
  assign w_push  = rx_valid && r_pst == P_ARG && !w_full;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge SYS_CLK or negedge n_reset) begin
    if (!n_reset) begin
      r_pst   <= P_ADDR;
      r_ptype <= 1'b0;
      r_paddr <= '0;
      r_ovf   <= 1'b0;
    end else if (rx_valid) begin
      if (r_pst == P_ARG) begin
        r_pst <= P_ADDR;
        if (w_full) r_ovf <= 1'b1;
      end else if (rx_data <= 8'h1F || rx_data == 8'h80) begin
        r_pst   <= P_ARG;
        r_ptype <= rx_data[7];
        r_paddr <= rx_data;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (w_push) r_mem[r_wptr] <= {r_ptype, r_paddr, rx_data};
  end

  always_ff @(posedge SYS_CLK or negedge n_reset) begin
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Only IDLE consumes the queue, so WRITE/WAIT naturally space out pops.
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_ncs_nxt = r_ncs;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (clk_en && !w_empty) begin
          w_pop = 1'b1;
          if (w_head[16]) begin
            if (w_head[7:0] != 8'd0) begin
              w_st_nxt  = S_WAIT;
              w_cnt_nxt = w_head[7:0];
            end
          end else begin
            w_load    = 1'b1;
            w_ncs_nxt = 1'b0;
            w_st_nxt  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (clk_en) begin
          w_ncs_nxt = 1'b1;
          w_st_nxt  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (clk_en) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == 8'd1) w_st_nxt = S_IDLE;
        end
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge n_reset) begin
    if (!n_reset) begin
      r_st   <= S_IDLE;
      r_cnt  <= '0;
      r_ncs  <= 1'b1;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
      r_ncs <= w_ncs_nxt;
      if (w_load) begin
        r_addr <= w_head[15:8];
        r_data <= w_head[7:0];
      end
    end
  end

  assign rx_ready   = !w_full;
  assign sid_addr   = r_addr;
  assign sid_data   = r_data;
  assign sid_n_cs   = r_ncs;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;
  assign busy       = !w_empty || r_st != S_IDLE;

endmodule

// File: doc/sid_write_sched.md
SID_WRITE_SCHED -- requirements
Module: sid_write_sched

Interface
REQ-001 SHALL have parameter: DEPTH, 16, FIFO entries (power of two, >=4).
REQ-002 SHALL have port: SYS_CLK  in  1  system clock (50 MHz).
REQ-003 SHALL have port: n_reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: clk_en  in  1  one-cycle SID tick (1 MHz), synchronous to SYS_CLK.
REQ-005 SHALL have port: rx_data  in  8  command byte from UART receiver.
REQ-006 SHALL have port: rx_valid  in  1  rx_data valid, single-cycle strobe.
REQ-007 SHALL have port: rx_ready  out  1  advisory, equals !fifo_full.
REQ-008 SHALL have port: sid_addr  out  8  SID register address.
REQ-009 SHALL have port: sid_data  out  8  SID write data.
REQ-010 SHALL have port: sid_n_cs  out  1  SID chip select, active-low.
REQ-011 SHALL have port: fifo_level  out  clog2(DEPTH)+1  occupied entries.
REQ-012 SHALL have port: overflow  out  1  sticky, command dropped.
REQ-013 SHALL have port: busy  out  1  FIFO non-empty or issue FSM not IDLE.

Function
REQ-014 SHALL parse bytes with parser states ADDR/ARG: byte 0x00-0x1F in ADDR -> WRITE command, go ARG; byte 0x80 in ADDR -> WAIT command, go ARG; any other byte in ADDR -> ignored, stay ADDR.
REQ-015 SHALL, on the ARG byte, push one 17-bit entry {type, addr, arg} and return to ADDR.
REQ-016 SHALL evaluate full before any same-cycle pop; if full when the ARG byte arrives, drop the pair, set overflow, and return to ADDR.
REQ-017 SHALL update fifo_level each cycle: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-018 SHALL run issue FSM states IDLE, WRITE, WAIT, and SHALL pop only in IDLE, only on a cycle with clk_en=1 and FIFO non-empty.
REQ-019 SHALL, on WRITE pop at tick k, register sid_addr/sid_data, drive sid_n_cs=0 from the next cycle, and enter WRITE.
REQ-020 SHALL, in WRITE on the next clk_en (tick k+1), drive sid_n_cs=1 on the following cycle and return to IDLE; earliest next pop at tick k+2.
REQ-021 SHALL hold sid_addr/sid_data stable while sid_n_cs=0, and retain the last values afterwards.
REQ-022 SHALL, on WAIT pop of N at tick k, return to IDLE (N=0) or load counter=N and enter WAIT; in WAIT each clk_en decrements the counter, exiting to IDLE on the tick where counter=1; next pop exactly at tick k+N+1.
REQ-023 SHALL ignore clk_en in IDLE when FIFO empty (no state change).
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-025 SHALL clear overflow only by reset.

Reset
REQ-026 SHALL, while n_reset=0 (asynchronously), force sid_n_cs=1, sid_addr=0, sid_data=0, fifo_level=0, overflow=0, busy=0, rx_ready=1, parser ADDR, FSM IDLE, wait counter 0, pointers 0.
REQ-027 SHALL, on reset asserted during WRITE, release sid_n_cs to 1 immediately and discard all queued entries and any half-received pair.

Verification
REQ-028 SHALL verify: bytes 0x18,0x0F, ticks every 50 cycles -> one pulse of sid_n_cs=0 spanning exactly one tick period with sid_addr=0x18, sid_data=0x0F; busy low afterwards.
REQ-029 SHALL verify: 0x80,0x05 then 0x04,0x11 queued before tick k -> WAIT popped at k, write popped at k+6, sid_n_cs low between ticks k+6 and k+7.
REQ-030 SHALL verify: 0x25 then 0x01,0x41 -> 0x25 ignored; single write addr 0x01 data 0x41; no overflow.
REQ-031 SHALL verify: DEPTH+1 pairs with clk_en held 0 -> fifo_level=DEPTH, rx_ready=0, overflow=1; with ticks enabled, exactly DEPTH writes issued in order, spanning the pointer wrap.
REQ-032 SHALL verify: n_reset pulsed low mid-WRITE with 3 entries queued -> sid_n_cs=1 within the reset cycle, fifo_level=0, no further writes after release.
REQ-033 SHALL verify: push and pop in the same cycle at fifo_level=3 -> fifo_level stays 3.
